// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central controller for the five-stage IF/ID/EXE/MEM/WB pipeline.
// - RAW hazard detection between ID and EXE/MEM; issues bubble/freeze.
// - Taken branch in EXE flushes IF and ID stage registers.
// - Multi-cycle data-memory accesses freeze the whole pipeline for MEM_LAT-1 cycles.
// - Saturating event counters for bring-up/performance debug.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   fwd_en                   forwarding present: only load-use stalls needed
//   src1, src2, two_src      ID source registers, src2 valid flag
//   exe_dest/exe_wb_en/exe_mem_r_en   EXE destination, writeback, load flag
//   mem_dest/mem_wb_en       MEM destination, writeback
//   mem_r_en, mem_w_en       MEM-stage memory request
//   branch_taken             taken branch resolved in EXE
//   cnt_clr                  synchronous clear of all counters
//   hazard, freeze, flush, pipe_stall   pipeline control outputs
//   hz_count, mem_stall_count, flush_count   event counters
//
// Memory FSM:
//   state  | meaning
//   M_IDLE | no access in flight; a request starts the stall window
//   M_WAIT | access in flight; wcnt counts remaining stall cycles
module pipe_hazard_ctrl #(
  parameter int MEM_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fwd_en,
  input  logic [3:0]       src1,
  input  logic [3:0]       src2,
  input  logic             two_src,
  input  logic [3:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             mem_r_en,
  input  logic             mem_w_en,
  input  logic             branch_taken,
  input  logic             cnt_clr,
  output logic             hazard,
  output logic             freeze,
  output logic             flush,
  output logic             pipe_stall,
  output logic [CNT_W-1:0] hz_count,
  output logic [CNT_W-1:0] mem_stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {M_IDLE, M_WAIT} mstate_t;

  localparam bit         MULTI     = (MEM_LAT > 1);
  // First stall cycle is issued from M_IDLE, so M_WAIT needs MEM_LAT-2 more.
  localparam logic [3:0] WAIT_INIT = MULTI ? 4'(MEM_LAT - 2) : 4'd0;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  mstate_t    state;
  logic [3:0] wcnt;
  logic       req;
  logic       exe_hit;
  logic       mem_hit;
  logic       raw_hz;
  logic       stall_c;

  assign req     = mem_r_en | mem_w_en;
  assign exe_hit = exe_wb_en & ((src1 == exe_dest) | (two_src & (src2 == exe_dest)));
  assign mem_hit = mem_wb_en & ((src1 == mem_dest) | (two_src & (src2 == mem_dest)));
  assign raw_hz  = fwd_en ? (exe_hit & exe_mem_r_en) : (exe_hit | mem_hit);

  always_comb begin
    stall_c = 1'b0;
    case (state)
      M_IDLE:  stall_c = req & MULTI;
      M_WAIT:  stall_c = (wcnt != 4'd0);
      default: stall_c = 1'b0;
    endcase
  end

  // Outputs are forced low while reset is held, even though they are combinational.
  assign pipe_stall = stall_c & ~rst;
  assign flush      = branch_taken & ~pipe_stall & ~rst;
  assign hazard     = raw_hz & ~branch_taken & ~pipe_stall & ~rst;
  assign freeze     = hazard | pipe_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= M_IDLE;
      wcnt  <= 4'd0;
    end else begin
      case (state)
        M_IDLE: begin
          if (req && MULTI) begin
            state <= M_WAIT;
            wcnt  <= WAIT_INIT;
          end
        end
        M_WAIT: begin
          if (wcnt != 4'd0) wcnt <= wcnt - 4'd1;
          else              state <= M_IDLE;
        end
        default: state <= M_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hz_count        <= '0;
      mem_stall_count <= '0;
      flush_count     <= '0;
    end else if (cnt_clr) begin
      hz_count        <= '0;
      mem_stall_count <= '0;
      flush_count     <= '0;
    end else begin
      if (hazard && hz_count != CNT_MAX)            hz_count        <= hz_count + 1'b1;
      if (pipe_stall && mem_stall_count != CNT_MAX) mem_stall_count <= mem_stall_count + 1'b1;
      if (flush && flush_count != CNT_MAX)          flush_count     <= flush_count + 1'b1;
    end
  end

endmodule
